// File: rtl/cache_fill_fsm.sv
// Miss-driven cache line fill controller: issues 8 word reads for a 16-byte block,
// writes each returned word into the data array and writes the tag on the last word.
module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        mem_read_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        write_tag_array
);

    typedef enum logic {StIdle, StFill} state_e;

    state_e      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [3:0]  req_cnt_q, req_cnt_d;
    logic [2:0]  ret_cnt_q, ret_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            base_q    <= 16'h0000;
            req_cnt_q <= 4'd0;
            ret_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        req_cnt_d        = req_cnt_q;
        ret_cnt_d        = ret_cnt_q;
        fsm_busy         = (state_q == StFill);
        mem_read_en      = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        fill_word        = 3'd0;
        fill_data        = 16'h0000;
        write_tag_array  = 1'b0;

        case (state_q)
            StIdle: begin
                if (miss_detected) begin
                    state_d   = StFill;
                    base_d    = {miss_address[15:4], 4'h0};
                    req_cnt_d = 4'd0;
                    ret_cnt_d = 3'd0;
                end
            end
            StFill: begin
                // Requests stream out unconditionally; memory never back-pressures.
                if (req_cnt_q < 4'd8) begin
                    mem_read_en    = 1'b1;
                    memory_address = base_q + {11'b0, req_cnt_q, 1'b0};
                    req_cnt_d      = req_cnt_q + 4'd1;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_word        = ret_cnt_q;
                    fill_data        = memory_data;
                    ret_cnt_d        = ret_cnt_q + 3'd1;
                    // Only the 8th returned word completes the fill.
                    if (ret_cnt_q == 3'd7) begin
                        write_tag_array = 1'b1;
                        state_d         = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have this port list, one line per port (name, direction, width, meaning), with clock and reset first.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- miss_detected  in  1  cache miss in the memory stage this cycle.
- miss_address  in  16  byte address of the missing access.
- memory_data_valid  in  1  main memory returns a word this cycle.
- memory_data  in  16  returned word.
- fsm_busy  out  1  fill in progress; stalls the pipeline.
- mem_read_en  out  1  read request to main memory this cycle.
- memory_address  out  16  byte address of the request.
- write_data_array  out  1  write fill_data into the cache data array.
- fill_word  out  3  word index within the block for write_data_array.
- fill_data  out  16  word to write; equals memory_data.
- write_tag_array  out  1  write the tag and valid bit for the filled block.

REQ-002 Block geometry SHALL be fixed at 8 words of 16 bits (16 bytes) per block, with no parameters.

Function
REQ-003 The FSM SHALL have exactly two states, IDLE and FILL, held in a register.

REQ-004 In IDLE with miss_detected=1, the block SHALL latch base = miss_address & 16'hFFF0, clear both counters, and enter FILL at the next edge.

REQ-005 fsm_busy SHALL equal (state==FILL) and SHALL be a registered value, not a function of miss_detected.

REQ-006 The request counter (4 bits) SHALL run 0..8.
- In FILL with req_cnt<8: mem_read_en=1 and memory_address = base + 2*req_cnt; req_cnt increments each cycle.
- Otherwise: mem_read_en=0 and memory_address=0.

REQ-007 Requests SHALL issue on 8 consecutive cycles starting the first FILL cycle, with no back-pressure from memory.

REQ-008 The return counter (3 bits) SHALL work as follows.
- In FILL with memory_data_valid=1: write_data_array=1, fill_word=ret_cnt, fill_data=memory_data, and ret_cnt increments.
- Otherwise write_data_array=0.

REQ-009 On the valid with ret_cnt==7, the block SHALL set write_tag_array=1 in that same cycle and return to IDLE at the next edge.
- write_tag_array SHALL be 0 at all other times.

REQ-010 memory_data_valid while in IDLE SHALL be ignored: no array writes, no counter change.

REQ-011 miss_detected while in FILL, including the completing cycle, SHALL be ignored; a new miss SHALL be accepted only on a cycle where state==IDLE.

REQ-012 Completion SHALL be driven only by the 8th valid, independent of memory latency; for a 4-cycle memory, a miss sampled at cycle N gives:
- fsm_busy=1 on cycles N+1..N+12;
- write_tag_array=1 at N+12;
- fsm_busy=0 at N+13.

REQ-013 Address arithmetic SHALL be 16-bit without carry-out; for base 16'hFFF0 the last request SHALL be 16'hFFFE, and no address SHALL wrap.

REQ-014 fill_data SHALL be 16'h0000 whenever write_data_array=0; fill_word SHALL be 0 whenever write_data_array=0.

Reset
REQ-015 With rst=1 at an edge, the block SHALL force:
- state=IDLE, base=0, req_cnt=0, ret_cnt=0;
- all outputs to 0 from the following cycle.

REQ-016 rst SHALL take priority over miss_detected and memory_data_valid in the same cycle.

REQ-017 Reset during FILL SHALL abort the fill with no write_tag_array pulse; memory valids still returning after reset SHALL be ignored per REQ-010.

Verification
REQ-018 Basic miss: miss_address=16'h1236 at cycle N with a 4-cycle memory returning data 16'hA000+i.
- Requests at 16'h1230..16'h123E on N+1..N+8.
- write_data_array with fill_word 0..7 and data 16'hA000..A007 on N+5..N+12.
- write_tag_array at N+12; fsm_busy=0 at N+13.

REQ-019 Top block: miss_address=16'hFFFF.
- base=16'hFFF0; last request 16'hFFFE; no wrap to 16'h0000.

REQ-020 Miss during fill: miss_detected=1 with miss_address=16'h4000 on N+3 and N+12.
- No re-latch and no extra requests.
- A miss on N+13 starts a new fill with a request at 16'h4000 on N+14.

REQ-021 Gapped returns: valids with random 0-3 cycle gaps.
- Exactly 8 data writes in order 0..7.
- write_tag_array coincides with the 8th valid; fsm_busy stays 1 until then.

REQ-022 Reset mid-fill: rst=1 at N+6 during a fill.
- All outputs 0 at N+7.
- The remaining valids on N+7..N+12 produce no writes and no write_tag_array.
- A fresh miss after reset completes normally.

REQ-023 Spurious valid: memory_data_valid=1 in IDLE with no miss.
- write_data_array=0 and fsm_busy=0 throughout.
